// File: rtl/grid_wb_sequencer_pkg.sv
// rtl/grid_wb_sequencer_pkg.sv - shared types and constants for the grid writeback sequencer
package rca_config;

    localparam int NUM_WRITE_PORTS = 2;
    localparam int WB_SEQ_ID_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GRID,
        DRAIN
    } wb_seq_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       used;
    } wb_port_cmd_t;

endpackage

// File: rtl/rca_wb_port_picker.sv
// rtl/rca_wb_port_picker.sv - finds the lowest used port at (INCLUSIVE) or above idx
// last is set when no such port exists, i.e. the search ran off the end of the mask.
module rca_wb_port_picker #(
    parameter int N         = 2,
    parameter int IW        = 1,
    parameter bit INCLUSIVE = 1'b0
) (
    input  logic [N-1:0]  used,
    input  logic [IW-1:0] idx,
    output logic [IW-1:0] next_idx,
    output logic          last
);

    always_comb begin
        next_idx = '0;
        last     = 1'b1;
        // Scan downwards so the lowest qualifying port is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (used[i] && (INCLUSIVE ? (i >= int'(idx)) : (i > int'(idx)))) begin
                next_idx = IW'(i);
                last     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/grid_wb_sequencer.sv
// rtl/grid_wb_sequencer.sv - arms grid writeback, captures results, drains them one per ack
// Optional: RCA_WB_SKIP_X0_EN drops ports whose destination is x0 at start.
module grid_wb_sequencer #(
    parameter int NUM_WRITE_PORTS = rca_config::NUM_WRITE_PORTS,
    parameter int XLEN            = 32,
    parameter int ID_W            = rca_config::WB_SEQ_ID_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ID_W-1:0]                       start_id,
    input  logic [NUM_WRITE_PORTS-1:0][4:0]       start_rd,
    input  logic [NUM_WRITE_PORTS-1:0]            start_rd_used,
    output logic                                  io_unit_sels_valid,
    input  logic                                  wb_committing,
    input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  grid_data,
    output logic                                  wb_valid,
    output logic [4:0]                            wb_rd,
    output logic [XLEN-1:0]                       wb_data,
    output logic [ID_W-1:0]                       wb_id,
    input  logic                                  wb_ack,
    output logic                                  busy,
    output logic                                  done
);

    import rca_config::*;

    localparam int IW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    wb_seq_state_t                        state, state_next;
    wb_port_cmd_t                         cmd_q     [NUM_WRITE_PORTS];
    wb_port_cmd_t                         start_cmd [NUM_WRITE_PORTS];
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] buf_q;
    logic [ID_W-1:0]                      id_q;
    logic [IW-1:0]                        idx_q, idx_next;
    logic                                 done_q, done_next;
    logic                                 latch_start, capture;
    logic [NUM_WRITE_PORTS-1:0]           used_mask;
    logic [IW-1:0]                        first_idx, adv_idx;
    logic                                 first_none, adv_last;

    always_comb begin
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            start_cmd[i].rd = start_rd[i];
`ifdef RCA_WB_SKIP_X0_EN
            start_cmd[i].used = start_rd_used[i] && (start_rd[i] != 5'd0);
`else
            start_cmd[i].used = start_rd_used[i];
`endif
            used_mask[i] = cmd_q[i].used;
        end
    end

    rca_wb_port_picker #(
        .N         (NUM_WRITE_PORTS),
        .IW        (IW),
        .INCLUSIVE (1'b1)
    ) u_first_pick (
        .used     (used_mask),
        .idx      ('0),
        .next_idx (first_idx),
        .last     (first_none)
    );

    rca_wb_port_picker #(
        .N         (NUM_WRITE_PORTS),
        .IW        (IW),
        .INCLUSIVE (1'b0)
    ) u_adv_pick (
        .used     (used_mask),
        .idx      (idx_q),
        .next_idx (adv_idx),
        .last     (adv_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            id_q   <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            buf_q  <= '0;
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                cmd_q[i] <= '0;
            end
        end else begin
            state  <= state_next;
            idx_q  <= idx_next;
            done_q <= done_next;
            if (latch_start) begin
                id_q  <= start_id;
                cmd_q <= start_cmd;
            end
            if (capture) begin
                buf_q <= grid_data;
            end
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx_q;
        done_next   = 1'b0;
        latch_start = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_start = 1'b1;
                    state_next  = WAIT_GRID;
                end
            end
            WAIT_GRID: begin
                if (wb_committing) begin
                    capture = 1'b1;
                    if (first_none) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next   = first_idx;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Advance is registered, so wb_ack never reaches wb_valid combinationally.
                if (wb_ack) begin
                    if (adv_last) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = adv_idx;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign io_unit_sels_valid = (state == WAIT_GRID);
    assign wb_valid           = (state == DRAIN);
    assign wb_rd              = wb_valid ? cmd_q[idx_q].rd : 5'd0;
    assign wb_data            = wb_valid ? buf_q[idx_q] : '0;
    assign wb_id              = id_q;
    assign busy               = (state != IDLE);
    assign done               = done_q;

endmodule

// File: tb/tb_grid_wb_sequencer.sv
// tb/tb_grid_wb_sequencer.sv - table-driven bench for grid_wb_sequencer
module tb_grid_wb_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        start_id;
    logic [1:0][4:0]   start_rd;
    logic [1:0]        start_rd_used;
    logic              io_unit_sels_valid;
    logic              wb_committing;
    logic [1:0][31:0]  grid_data;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic [2:0]        wb_id;
    logic              wb_ack;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grid_wb_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .start_id           (start_id),
        .start_rd           (start_rd),
        .start_rd_used      (start_rd_used),
        .io_unit_sels_valid (io_unit_sels_valid),
        .wb_committing      (wb_committing),
        .grid_data          (grid_data),
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .wb_id              (wb_id),
        .wb_ack             (wb_ack),
        .busy               (busy),
        .done               (done)
    );

    typedef struct {
        logic [1:0]  used;
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        logic [2:0]  id;
        int          n;
        logic [4:0]  erd [2];
        logic [31:0] edat [2];
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_sels"},  32'(io_unit_sels_valid), 32'd0);
        chk({tag, "_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_rd"},    32'(wb_rd), 32'd0);
        chk({tag, "_data"},  wb_data, 32'd0);
        chk({tag, "_id"},    32'(wb_id), 32'd0);
    endtask

    task automatic issue(input vec_t v);
        start         = 1'b1;
        start_id      = v.id;
        start_rd      = {v.rd1, v.rd0};
        start_rd_used = v.used;
        tick();
        start = 1'b0;
        chk("wait_sels", 32'(io_unit_sels_valid), 32'd1);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_novalid", 32'(wb_valid), 32'd0);
        tick();
        chk("wait_sels_hold", 32'(io_unit_sels_valid), 32'd1);
        wb_committing = 1'b1;
        grid_data     = {v.d1, v.d0};
        tick();
        wb_committing = 1'b0;
        grid_data     = {32'hDEAD_0001, 32'hDEAD_0000};
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        issue(v);
        wb_ack = 1'b1;
        for (int k = 0; k < v.n; k++) begin
            chk($sformatf("v%0d_valid%0d", vi, k), 32'(wb_valid), 32'd1);
            chk($sformatf("v%0d_sels%0d", vi, k), 32'(io_unit_sels_valid), 32'd0);
            chk($sformatf("v%0d_rd%0d", vi, k), 32'(wb_rd), 32'(v.erd[k]));
            chk($sformatf("v%0d_data%0d", vi, k), wb_data, v.edat[k]);
            chk($sformatf("v%0d_id%0d", vi, k), 32'(wb_id), 32'(v.id));
            tick();
        end
        wb_ack = 1'b0;
        chk($sformatf("v%0d_done", vi), 32'(done), 32'd1);
        chk($sformatf("v%0d_busy_at_done", vi), 32'(busy), 32'd0);
        chk($sformatf("v%0d_novalid_at_done", vi), 32'(wb_valid), 32'd0);
        tick();
        chk($sformatf("v%0d_done_pulse", vi), 32'(done), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        start_id      = '0;
        start_rd      = '0;
        start_rd_used = '0;
        wb_committing = 1'b0;
        grid_data     = '0;
        wb_ack        = 1'b0;

        vecs[0] = '{used: 2'b11, rd0: 5'd5,  rd1: 5'd7, d0: 32'hA000_0005, d1: 32'hB000_0007,
                    id: 3'd1, n: 2, erd: '{5'd5, 5'd7}, edat: '{32'hA000_0005, 32'hB000_0007}};
        vecs[1] = '{used: 2'b10, rd0: 5'd4,  rd1: 5'd9, d0: 32'h1111_1111, d1: 32'h2222_2222,
                    id: 3'd2, n: 1, erd: '{5'd9, 5'd0}, edat: '{32'h2222_2222, 32'h0}};
        vecs[2] = '{used: 2'b00, rd0: 5'd1,  rd1: 5'd2, d0: 32'h3333_3333, d1: 32'h4444_4444,
                    id: 3'd3, n: 0, erd: '{5'd0, 5'd0}, edat: '{32'h0, 32'h0}};
        vecs[3] = '{used: 2'b01, rd0: 5'd12, rd1: 5'd0, d0: 32'h5555_AAAA, d1: 32'h6666_BBBB,
                    id: 3'd4, n: 1, erd: '{5'd12, 5'd0}, edat: '{32'h5555_AAAA, 32'h0}};
`ifdef RCA_WB_SKIP_X0_EN
        vecs[4] = '{used: 2'b11, rd0: 5'd0,  rd1: 5'd3, d0: 32'h7777_0000, d1: 32'h8888_0003,
                    id: 3'd5, n: 1, erd: '{5'd3, 5'd0}, edat: '{32'h8888_0003, 32'h0}};
`else
        vecs[4] = '{used: 2'b11, rd0: 5'd0,  rd1: 5'd3, d0: 32'h7777_0000, d1: 32'h8888_0003,
                    id: 3'd5, n: 2, erd: '{5'd0, 5'd3}, edat: '{32'h7777_0000, 32'h8888_0003}};
`endif

        tick();
        tick();
        chk_idle_zero("reset");
        rst_n = 1'b1;

        // A commit seen while idle must not start anything.
        wb_committing = 1'b1;
        tick();
        wb_committing = 1'b0;
        chk("idle_commit_busy", 32'(busy), 32'd0);
        chk("idle_commit_done", 32'(done), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Ack held low: offer stays put; a start during DRAIN is dropped.
        issue(vecs[0]);
        wb_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                start         = 1'b1;
                start_id      = 3'd6;
                start_rd      = {5'd20, 5'd21};
                start_rd_used = 2'b11;
            end
            tick();
            start = 1'b0;
            chk($sformatf("stall_valid%0d", k), 32'(wb_valid), 32'd1);
            chk($sformatf("stall_rd%0d", k), 32'(wb_rd), 32'd5);
            chk($sformatf("stall_data%0d", k), wb_data, 32'hA000_0005);
            chk($sformatf("stall_id%0d", k), 32'(wb_id), 32'd1);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("stall_adv_rd", 32'(wb_rd), 32'd7);
        chk("stall_adv_data", wb_data, 32'hB000_0007);
        tick();
        chk("stall_adv_hold_rd", 32'(wb_rd), 32'd7);
        chk("stall_adv_hold_valid", 32'(wb_valid), 32'd1);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        // Start accepted in the very cycle done is high.
        start         = 1'b1;
        start_id      = 3'd7;
        start_rd      = {5'd7, 5'd5};
        start_rd_used = 2'b11;
        tick();
        start = 1'b0;
        chk("b2b_sels", 32'(io_unit_sels_valid), 32'd1);
        chk("b2b_id", 32'(wb_id), 32'd7);
        wb_committing = 1'b1;
        grid_data     = {32'hC0DE_0002, 32'hC0DE_0001};
        tick();
        wb_committing = 1'b0;
        chk("b2b_valid", 32'(wb_valid), 32'd1);
        chk("b2b_data", wb_data, 32'hC0DE_0001);

        // Reset mid-DRAIN discards everything.
        rst_n = 1'b0;
        tick();
        chk_idle_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_stay_idle", 32'(busy), 32'd0);
        chk("midrst_no_valid", 32'(wb_valid), 32'd0);
        run_vec(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_wb_sequencer.md
# grid_wb_sequencer

Sequences the grid writeback path for one accelerator instruction. It arms the grid writeback selection and waits for every selected port to commit. It then captures the results and drains them one at a time onto the core's single-register writeback handshake. It sits between the grid writeback mux, which supplies data and the commit indication, and the Taiga writeback/commit logic.

## Interface
- NUM_WRITE_PORTS, default rca_config::NUM_WRITE_PORTS (2): grid write ports per instruction.
- XLEN, default 32: data width.
- ID_W, default 3: instruction id width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  pulse; new accelerator instruction issued. Ignored while busy.
- start_id  in  ID_W  instruction id, latched on accepted start.
- start_rd  in  [NUM_WRITE_PORTS][5]  destination register per port.
- start_rd_used  in  [NUM_WRITE_PORTS]  port carries a result.
- io_unit_sels_valid  out  1  arms grid writeback selection.
- wb_committing  in  1  all selected grid ports hold valid data.
- grid_data  in  [NUM_WRITE_PORTS][XLEN]  per-port grid writeback data.
- wb_valid  out  1  result offered to core.
- wb_rd  out  5  destination register of offered result.
- wb_data  out  XLEN  offered result.
- wb_id  out  ID_W  latched instruction id.
- wb_ack  in  1  core accepts offered result this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse: instruction fully written back.

## Operation
- Reset: state IDLE. io_unit_sels_valid, wb_valid, busy, done = 0. wb_rd, wb_data, wb_id = 0. Capture buffer cleared.
- IDLE: on start, latch start_id, start_rd and the used mask, then go to WAIT_GRID.
- WAIT_GRID: io_unit_sels_valid = 1. On wb_committing, capture grid_data for all ports into the buffer and set idx to the lowest used port.
  - If no port is used: pulse done and return to IDLE.
  - Otherwise go to DRAIN.
- DRAIN: wb_valid = 1, with wb_rd/wb_data taken from buffer[idx]. Outputs stay stable until wb_ack.
  - On wb_ack with remaining used ports: idx advances to the next higher used port.
  - On wb_ack at the last used port: pulse done and go to IDLE.
- io_unit_sels_valid = 0 outside WAIT_GRID. wb_committing is ignored outside WAIT_GRID.
- start while busy is dropped; the issue logic must not issue then.
- Reset asserted mid-instruction discards buffered results; no partial writeback continues.

## Timing
- start sampled at cycle 0; WAIT_GRID and io_unit_sels_valid = 1 from cycle 1.
- wb_committing sampled at cycle N; first wb_valid at N+1.
- With wb_ack held high, one result is written per cycle.
- done is high in the cycle after the final ack, or the cycle after commit when no port is used. busy is 0 in that cycle, so a new start is accepted in that same cycle.
- The wb_ack-to-next-port path is registered; wb_ack has no combinational path to wb_valid.

## Configuration
- RCA_WB_SKIP_X0_EN defined: a port with start_rd == 0 is treated as unused at start. Its result is captured but never offered, which saves a writeback cycle.
- Undefined: only start_rd_used gates ports. rd = 0 results are offered normally, and the core discards them.

## Structure
- rca_config package:
  - wb_seq_state_t enum {IDLE, WAIT_GRID, DRAIN}.
  - wb_port_cmd_t struct {rd[4:0], used}.
  - WB_SEQ_ID_W constant.
- Sub-module rca_wb_port_picker (combinational): given the used mask and current idx, outputs next_idx and last. It is instantiated twice: once for the first-port pick and once for the advance.

## Test plan
- Both ports used, rd={5,7}, commit at cycle 3, ack always high -> wb_valid cycles 4-5 with rd 5 then 7 and matching data; done at cycle 6.
- Used mask 2'b10, rd[1]=9 -> one offer with rd 9; done one cycle after its ack.
- Used mask 0 -> no wb_valid; done in the cycle after commit.
- wb_ack held low 4 cycles in DRAIN -> wb_rd/wb_data/wb_valid stable throughout; advance only on ack.
- start pulsed during DRAIN; rst_n low mid-DRAIN -> second start ignored; reset gives IDLE with all outputs 0, and a following start behaves normally.
- RCA_WB_SKIP_X0_EN set, rd={0,3}, both used -> only rd 3 offered; unset -> rd 0 then rd 3 offered.
